// File: rtl/wide_mult_top.sv
// rtl/wide_mult_top.sv - 43-stage pipelined A + B*2^64 + C*(D + floor(C*E/2)), modulo 2^256
module wide_mult_top #(
    parameter int LATENCY = 43
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         start,
    input  logic [127:0] A,
    input  logic [63:0]  B,
    input  logic [63:0]  C,
    input  logic [127:0] D,
    input  logic [127:0] E,
    output logic [255:0] return_val
);

    function automatic logic [127:0] mul64(input logic [63:0] x, input logic [63:0] y);
        return {64'b0, x} * {64'b0, y};
    endfunction

    // Stage n holds values written on the n-th edge after sampling (stage 0 = input capture).
    logic [127:0] a_q [0:5];
    logic [63:0]  b_q [0:5];
    logic [63:0]  c_q [0:3];
    logic [127:0] d_q [0:2];
    logic [127:0] e_q;

    logic [127:0] t1 [0:2][0:2];
    logic [191:0] p1;
    logic [191:0] s3;
    logic [127:0] t2 [0:3][0:3];
    logic [255:0] p2;
    logic [255:0] res6;
    logic [255:0] pad [7:LATENCY-1];
    logic [LATENCY-1:0] vld;

    logic [191:0] c_ext1, e_ext1, p1_sum;
    logic [255:0] c_ext4, s_ext4, p2_sum;

    // Signed products are formed as unsigned tile products of the sign-extended
    // operands, truncated to the product width; tiles beyond that width are zero.
    assign c_ext1 = {{128{c_q[0][63]}}, c_q[0]};
    assign e_ext1 = {{64{e_q[127]}}, e_q};
    assign c_ext4 = {{192{c_q[3][63]}}, c_q[3]};
    assign s_ext4 = {{64{s3[191]}}, s3};

    always_comb begin
        p1_sum = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p1_sum = p1_sum + ({64'b0, t1[i][j]} << (64 * (i + j)));
    end

    always_comb begin
        p2_sum = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                p2_sum = p2_sum + ({128'b0, t2[i][j]} << (64 * (i + j)));
    end

    always_ff @(posedge clock) begin
        a_q[0] <= A;
        b_q[0] <= B;
        c_q[0] <= C;
        d_q[0] <= D;
        e_q    <= E;
        for (int i = 1; i < 6; i++) begin
            a_q[i] <= a_q[i-1];
            b_q[i] <= b_q[i-1];
        end
        for (int i = 1; i < 4; i++) c_q[i] <= c_q[i-1];
        for (int i = 1; i < 3; i++) d_q[i] <= d_q[i-1];

        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                t1[i][j] <= (i + j < 3) ? mul64(c_ext1[64*i +: 64], e_ext1[64*j +: 64]) : '0;
        p1 <= p1_sum;
        // Arithmetic right shift by one floors toward minus infinity.
        s3 <= {{64{d_q[2][127]}}, d_q[2]} + {p1[191], p1[191:1]};

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                t2[i][j] <= (i + j < 4) ? mul64(c_ext4[64*i +: 64], s_ext4[64*j +: 64]) : '0;
        p2 <= p2_sum;
        res6 <= {128'b0, a_q[5]} + {128'b0, b_q[5], 64'b0} + p2;

        pad[7] <= res6;
        for (int i = 8; i < LATENCY; i++) pad[i] <= pad[i-1];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld        <= '0;
            return_val <= '0;
        end else begin
            vld <= {vld[LATENCY-2:0], start};
            if (vld[LATENCY-1]) return_val <= pad[LATENCY-1];
        end
    end

endmodule

// File: tb/tb_wide_mult_top.sv
// tb/tb_wide_mult_top.sv - scoreboard bench for wide_mult_top
module tb_wide_mult_top;

    localparam int LAT = 43;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic [127:0] A = '0;
    logic [63:0]  B = '0;
    logic [63:0]  C = '0;
    logic [127:0] D = '0;
    logic [127:0] E = '0;
    logic [255:0] return_val;

    wide_mult_top #(.LATENCY(LAT)) dut (
        .clock(clock), .resetn(resetn), .start(start),
        .A(A), .B(B), .C(C), .D(D), .E(E),
        .return_val(return_val)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [255:0] exp;
        int           due;
    } ent_t;

    ent_t         q[$];
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;
    logic [255:0] last_exp = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] ref_model(input logic [127:0] a, input logic [63:0] b,
                                               input logic [63:0] c, input logic [127:0] d,
                                               input logic [127:0] e);
        logic signed [255:0] sc, se, sd, p1, h, s, p2;
        logic [191:0] s192;
        sc = {{192{c[63]}}, c};
        se = {{128{e[127]}}, e};
        sd = {{128{d[127]}}, d};
        p1 = sc * se;
        h = p1 >>> 1;
        s = sd + h;
        s192 = s[191:0];
        s = {{64{s192[191]}}, s192};
        p2 = sc * s;
        return {128'b0, a} + {128'b0, b, 64'b0} + p2;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Result due on the negedge following edge cyc+1+LAT; otherwise output must hold.
    always @(negedge clock) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            check("result", return_val, q[0].exp);
            last_exp = q[0].exp;
            void'(q.pop_front());
        end else begin
            check("hold", return_val, last_exp);
        end
    end

    task automatic send(input logic [127:0] a, input logic [63:0] b, input logic [63:0] c,
                        input logic [127:0] d, input logic [127:0] e, input logic [255:0] exp);
        ent_t en;
        @(negedge clock);
        start = 1'b1;
        A = a; B = b; C = c; D = d; E = e;
        en.exp = exp;
        en.due = cyc + 1 + LAT;
        q.push_back(en);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            start = 1'b0;
            A = rnd128(); B = $urandom; C = $urandom; D = rnd128(); E = rnd128();
        end
    endtask

    task automatic stream_vec(input int i);
        logic [127:0] a, d, e;
        logic [63:0]  b, c;
        a = rnd128(); b = {$urandom, $urandom}; c = {$urandom, $urandom};
        d = rnd128(); e = rnd128();
        case (i % 6)
            0: begin c = 64'h7FFF_FFFF_FFFF_FFFF; e = {1'b0, {127{1'b1}}}; end
            1: begin c = 64'h8000_0000_0000_0000; e = {1'b1, 127'b0}; end
            2: begin c = 64'h8000_0000_0000_0000; e = {1'b0, {127{1'b1}}}; d = 128'd9876543210; end
            3: begin c = 64'h7FFF_FFFF_FFFF_FFFF; e = {1'b1, 127'b0}; d = 128'd9876543210; end
            default: ;
        endcase
        send(a, b, c, d, e, ref_model(a, b, c, d, e));
    endtask

    initial begin
        logic [255:0] e31;
        e31 = {4'hF, 252'b0};

        #1 check("reset_state", return_val, '0);
        repeat (3) @(negedge clock);
        #3 resetn = 1'b1;
        idle(3);

        send(128'd2, 64'd2, 64'd2, 128'd2, 128'd2, 256'h2_0000_0000_0000_000A);
        idle(LAT + 5);
        send(128'd3, 64'd3, 64'd3, 128'd3, 128'd3, 256'h3_0000_0000_0000_0018);
        idle(4);
        send('0, '0, 64'hFFFF_FFFF_FFFF_FFFF, '0, 128'd1, 256'd1);
        send('0, '0, 64'h8000_0000_0000_0000, '0, {1'b1, 127'b0}, e31);
        idle(LAT + 5);

        for (int i = 0; i < 47; i++) stream_vec(i);
        idle(LAT + 5);

        // Reset mid-stream: in-flight results must vanish.
        for (int i = 0; i < 20; i++) stream_vec(i);
        @(negedge clock);
        #3;
        resetn = 1'b0;
        start = 1'b0;
        q.delete();
        last_exp = '0;
        #1 check("rst_async", return_val, '0);
        repeat (3) @(negedge clock);
        #3 resetn = 1'b1;
        idle(LAT + 5);

        for (int i = 0; i < 6; i++) stream_vec(i + 1);
        idle(LAT + 5);

        check("drain", 256'(q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wide_mult_top.md
WIDE_MULT_TOP -- requirements
Module: wide_mult_top

Interface
REQ-001 Parameter: LATENCY, default 43, sampling-edge-to-output-update latency in clock cycles; fixed, other values not supported.
REQ-002 Port: clock  input  1  rising-edge system clock.
REQ-003 Port: resetn  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  operand-valid strobe; inputs A..E are sampled on every rising edge where start=1.
REQ-005 Port: A  input  128  addend; unsigned, zero-extended to 256 bits.
REQ-006 Port: B  input  64  high addend; unsigned, weighted by 2^64.
REQ-007 Port: C  input  64  signed two's-complement multiplier.
REQ-008 Port: D  input  128  signed two's-complement addend.
REQ-009 Port: E  input  128  signed two's-complement multiplicand.
REQ-010 Port: return_val  output  256  registered result, two's-complement bit pattern.

Function
REQ-011 The block SHALL compute return_val = A + B*2^64 + C*(D + floor((C*E)/2)), modulo 2^256.
REQ-012 Stage P1: P1 = C*E as a signed 64x128 product, kept at the full 192 bits.
REQ-013 Stage H: H = P1 arithmetic-shifted right by 1 bit (sign bit replicated, rounding toward minus infinity).
- Example: C*E = -1 gives H = -1.
REQ-014 Stage S: S = sign-extend(D, 192) + H, kept at 192 bits with wrap.
REQ-015 Stage P2: P2 = C*S as a signed 64x192 product, kept at the full 256 bits.
REQ-016 Final sum: return_val = zero-extend(A) + zero-extend({B, 64'b0}) + P2, with 256-bit wrap and no saturation or overflow flag.
REQ-017 The pipeline SHALL be fully pipelined with initiation interval 1, accepting a new operand set every cycle start=1.
REQ-018 Operands sampled at rising edge k SHALL produce their result on return_val at rising edge k+43.
REQ-019 A valid bit SHALL travel with each operand set through all 43 stages.
REQ-020 return_val SHALL update only when a valid result exits the pipeline, and SHALL hold its last value otherwise.
REQ-021 Idle cycles (start=0) SHALL insert bubbles and SHALL never disturb in-flight results; result order equals input order.
REQ-022 Multipliers SHALL be decomposed into pipelined partial products (e.g. 64x64 or smaller tiles) so that the total latency is exactly 43.
REQ-023 Inputs SHALL be captured into registers on the sampling edge; the block SHALL not depend on inputs remaining stable afterward.

Reset
REQ-024 While resetn=0, return_val and all pipeline valid bits SHALL be 0, asynchronously.
REQ-025 Data registers inside the pipeline MAY also be cleared; clearing them SHALL not be required for correct operation.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight results; none SHALL appear after resetn rises.
REQ-027 The first sampling edge after reset release SHALL be the first rising edge with resetn=1 and start=1.

Verification
REQ-028 Minimal vector: A=2, B=2, C=2, D=2, E=2, single start pulse.
- Expected: 43 cycles later return_val = 0x2000000000000000A; no return_val change before that.
REQ-029 Vector A=B=C=D=E=3.
- Expected: return_val = 0x30000000000000018.
REQ-030 Floor-shift check: C=0xFFFFFFFFFFFFFFFF (-1), E=1, A=B=D=0.
- Expected: H=-1, return_val = 1.
REQ-031 Extreme signed values: C=0x8000000000000000, E=0x80000000000000000000000000000000, A=B=D=0.
- Expected: return_val = 0xF followed by 63 zero hex digits (-2^252).
REQ-032 Streaming: 47 consecutive cycles with start=1 and distinct vectors, including C and E at their maximum/minimum values and D=9876543210.
- Expected: 47 results on 47 consecutive cycles, first result at edge 43 after the first sampling edge, each matching a reference model of REQ-011.
REQ-033 Reset mid-stream: assert resetn=0 20 cycles into a stream.
- Expected: return_val = 0 immediately; it stays 0 with no further updates until new start-qualified inputs have traversed 43 cycles after release.
